// File: rtl/writeback_pipe.sv
// N-lane registered writeback stage: source select, kill/regwrite qualification, WAW suppression.
// Optional trace outputs (retire_cnt, trace_valid) are enabled by defining WB_TRACE_EN.
module writeback_pipe #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES-1:0]        in_regwrite,
  input  logic [LANES-1:0]        in_kill,
  input  logic [3*LANES-1:0]      in_sel,
  input  logic [DATA_W*LANES-1:0] in_pc,
  input  logic [ADDR_W*LANES-1:0] in_rdst,
  input  logic [DATA_W*LANES-1:0] in_alu,
  input  logic [DATA_W*LANES-1:0] in_mem,
  input  logic [DATA_W-1:0]       cp0_rd,
  input  logic [DATA_W-1:0]       hi_rd,
  input  logic [DATA_W-1:0]       lo_rd,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    in_ready,
  output logic [LANES-1:0]        wb_wen,
  output logic [ADDR_W*LANES-1:0] wb_wa,
  output logic [DATA_W*LANES-1:0] wb_wd,
  output logic [DATA_W*LANES-1:0] wb_pc
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]             retire_cnt,
  output logic [LANES-1:0]        trace_valid
`endif
);

  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 32;

  logic [LANES-1:0]        kill_chain_c;
  logic [LANES-1:0]        we_raw_c;
  logic [LANES-1:0]        we_c;
  logic [DATA_W*LANES-1:0] wd_c;
  logic                    killed_c;

  assign in_ready = ~stall;

  // Per-lane qualification, kill chain and source mux
  always_comb begin
    kill_chain_c = '0;
    we_raw_c     = '0;
    wd_c         = '0;
    killed_c     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      killed_c        = killed_c | in_kill[i];
      kill_chain_c[i] = killed_c;
      we_raw_c[i]     = in_valid[i] & in_regwrite[i] & ~killed_c &
                        (in_rdst[i*ADDR_W +: ADDR_W] != '0);
      case (in_sel[i*SEL_W +: SEL_W])
        3'd0:    wd_c[i*DATA_W +: DATA_W] = in_alu[i*DATA_W +: DATA_W];
        3'd1:    wd_c[i*DATA_W +: DATA_W] = in_mem[i*DATA_W +: DATA_W];
        3'd2:    wd_c[i*DATA_W +: DATA_W] = cp0_rd;
        3'd3:    wd_c[i*DATA_W +: DATA_W] = lo_rd;
        3'd4:    wd_c[i*DATA_W +: DATA_W] = hi_rd;
        default: wd_c[i*DATA_W +: DATA_W] = '0;
      endcase
    end
  end

  // WAW: an older lane loses its write when a younger lane targets the same register
  always_comb begin
    we_c = we_raw_c;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (we_raw_c[i] && we_raw_c[j] &&
            (in_rdst[i*ADDR_W +: ADDR_W] == in_rdst[j*ADDR_W +: ADDR_W])) begin
          we_c[i] = 1'b0;
        end
      end
    end
  end

  // Output register: flush beats stall beats load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_wen <= '0;
      wb_wa  <= '0;
      wb_wd  <= '0;
      wb_pc  <= '0;
    end else if (flush) begin
      wb_wen <= '0;
    end else if (!stall) begin
      wb_wen <= we_c;
      wb_wa  <= in_rdst;
      wb_wd  <= wd_c;
      wb_pc  <= in_pc;
    end
  end

`ifdef WB_TRACE_EN
  logic [CNT_W-1:0] pop_c;

  always_comb begin
    pop_c = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_c = pop_c + CNT_W'(we_c[i]);
    end
  end

  // Retired-write counter saturates at all-ones; only loaded edges count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt  <= '0;
      trace_valid <= '0;
    end else if (flush) begin
      trace_valid <= '0;
    end else if (!stall) begin
      trace_valid <= in_valid & ~kill_chain_c;
      if (retire_cnt > ({CNT_W{1'b1}} - pop_c)) begin
        retire_cnt <= {CNT_W{1'b1}};
      end else begin
        retire_cnt <= retire_cnt + pop_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_pipe.sv
// Randomized self-checking bench for writeback_pipe against a per-lane behavioural model.
module tb_writeback_pipe;
  localparam int unsigned LANES  = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LANES-1:0]        in_valid, in_regwrite, in_kill;
  logic [3*LANES-1:0]      in_sel;
  logic [DATA_W*LANES-1:0] in_pc, in_alu, in_mem;
  logic [ADDR_W*LANES-1:0] in_rdst;
  logic [DATA_W-1:0]       cp0_rd, hi_rd, lo_rd;
  logic                    stall, flush;
  logic                    in_ready;
  logic [LANES-1:0]        wb_wen;
  logic [ADDR_W*LANES-1:0] wb_wa;
  logic [DATA_W*LANES-1:0] wb_wd, wb_pc;
`ifdef WB_TRACE_EN
  logic [31:0]             retire_cnt;
  logic [LANES-1:0]        trace_valid;
`endif

  writeback_pipe #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_regwrite(in_regwrite), .in_kill(in_kill),
    .in_sel(in_sel), .in_pc(in_pc), .in_rdst(in_rdst),
    .in_alu(in_alu), .in_mem(in_mem),
    .cp0_rd(cp0_rd), .hi_rd(hi_rd), .lo_rd(lo_rd),
    .stall(stall), .flush(flush), .in_ready(in_ready),
    .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_pc(wb_pc)
`ifdef WB_TRACE_EN
    , .retire_cnt(retire_cnt), .trace_valid(trace_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference state: what the writeback registers should hold
  logic [LANES-1:0]        m_wen;
  logic [ADDR_W*LANES-1:0] m_wa;
  logic [DATA_W*LANES-1:0] m_wd, m_pc;
  logic [31:0]             m_cnt;
  logic [LANES-1:0]        m_tv;

  function automatic logic [DATA_W-1:0] pick_src(input int lane);
    case (in_sel[lane*3 +: 3])
      3'd0: return in_alu[lane*DATA_W +: DATA_W];
      3'd1: return in_mem[lane*DATA_W +: DATA_W];
      3'd2: return cp0_rd;
      3'd3: return lo_rd;
      3'd4: return hi_rd;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_wen = '0; m_wa = '0; m_wd = '0; m_pc = '0; m_cnt = 0; m_tv = '0;
  endtask

  // Apply the behavioural rules to the inputs currently driven
  task automatic model_edge();
    bit     killed [LANES];
    bit     wants  [LANES];
    bit     wins   [LANES];
    longint total;
    if (flush) begin
      m_wen = '0;
      m_tv  = '0;
      return;
    end
    if (stall) return;
    for (int i = 0; i < LANES; i++) begin
      killed[i] = 0;
      for (int k = 0; k <= i; k++) if (in_kill[k]) killed[i] = 1;
      wants[i] = in_valid[i] && in_regwrite[i] && !killed[i] &&
                 (in_rdst[i*ADDR_W +: ADDR_W] != 0);
    end
    total = m_cnt;
    for (int i = 0; i < LANES; i++) begin
      wins[i] = wants[i];
      for (int j = i + 1; j < LANES; j++)
        if (wants[j] && in_rdst[j*ADDR_W +: ADDR_W] == in_rdst[i*ADDR_W +: ADDR_W]) wins[i] = 0;
      m_wen[i] = wins[i];
      m_tv[i]  = in_valid[i] && !killed[i];
      m_wd[i*DATA_W +: DATA_W] = pick_src(i);
      if (wins[i]) total++;
    end
    m_cnt = (total > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(total);
    m_wa  = in_rdst;
    m_pc  = in_pc;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".wen"}, 128'(wb_wen), 128'(m_wen));
    check_eq({tag, ".wa"},  128'(wb_wa),  128'(m_wa));
    check_eq({tag, ".wd"},  128'(wb_wd),  128'(m_wd));
    check_eq({tag, ".pc"},  128'(wb_pc),  128'(m_pc));
`ifdef WB_TRACE_EN
    check_eq({tag, ".cnt"}, 128'(retire_cnt),  128'(m_cnt));
    check_eq({tag, ".tv"},  128'(trace_valid), 128'(m_tv));
`endif
  endtask

  // One clock: inputs already driven; check ready, advance model, sample after edge
  task automatic step(input string tag);
    #1;
    check_eq({tag, ".ready"}, 128'(in_ready), 128'(!stall));
    model_edge();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_regwrite = '0; in_kill = '0; in_sel = '0;
    in_pc = '0; in_rdst = '0; in_alu = '0; in_mem = '0;
    cp0_rd = '0; hi_rd = '0; lo_rd = '0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic set_lane(input int i, input bit v, input bit rw, input bit k,
                          input logic [2:0] sel, input logic [ADDR_W-1:0] rd,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] mem);
    in_valid[i] = v; in_regwrite[i] = rw; in_kill[i] = k;
    in_sel[i*3 +: 3] = sel;
    in_rdst[i*ADDR_W +: ADDR_W] = rd;
    in_alu[i*DATA_W +: DATA_W] = alu;
    in_mem[i*DATA_W +: DATA_W] = mem;
    in_pc[i*DATA_W +: DATA_W] = 32'h0040_0000 + 32'(i * 4);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    reset = 1'b0;
    step("idle_after_reset");
    check_eq("idle_wen", 128'(wb_wen), 128'(2'b00));

    // Two independent writes from ALU and MEM
    set_lane(0, 1, 1, 0, 3'd0, 5'd3, 32'h11, 32'h0);
    set_lane(1, 1, 1, 0, 3'd1, 5'd4, 32'h0, 32'hAB);
    step("dual");
    check_eq("dual_wen", 128'(wb_wen), 128'(2'b11));
    check_eq("dual_wd",  128'(wb_wd),  128'({32'hAB, 32'h11}));

    // WAW: youngest wins
    set_lane(0, 1, 1, 0, 3'd0, 5'd7, 32'h22, 32'h0);
    set_lane(1, 1, 1, 0, 3'd0, 5'd7, 32'h33, 32'h0);
    step("waw");
    check_eq("waw_wen", 128'(wb_wen), 128'(2'b10));
    check_eq("waw_wd1", 128'(wb_wd[DATA_W +: DATA_W]), 128'(32'h33));

    // Kill on older lane blocks both; kill on younger only blocks it
    set_lane(0, 1, 1, 1, 3'd0, 5'd1, 32'h1, 32'h0);
    set_lane(1, 1, 1, 0, 3'd0, 5'd2, 32'h2, 32'h0);
    step("kill0");
    check_eq("kill0_wen", 128'(wb_wen), 128'(2'b00));
    in_kill = 2'b10;
    step("kill1");
    check_eq("kill1_wen", 128'(wb_wen), 128'(2'b01));

    // Stall holds everything for 3 cycles while inputs change
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 1, 1, 0, 3'd0, 5'(9 + c), $urandom, 32'h0);
      set_lane(1, 1, 1, 0, 3'd1, 5'(12 + c), 32'h0, $urandom);
      step("stall");
      check_eq("stall_wen", 128'(wb_wen), 128'(2'b01));
    end
    flush = 1'b1;
    step("flush_stall");
    check_eq("flush_stall_wen", 128'(wb_wen), 128'(2'b00));
    stall = 1'b0; flush = 1'b0;

    // r0 never written; unused selects give zero data
    hi_rd = 32'h5;
    set_lane(0, 1, 1, 0, 3'd4, 5'd0, 32'h0, 32'h0);
    set_lane(1, 1, 1, 0, 3'd6, 5'd5, 32'hDEAD, 32'hBEEF);
    step("r0_sel6");
    check_eq("r0_wen", 128'(wb_wen), 128'(2'b10));
    check_eq("r0_wd",  128'(wb_wd),  128'({32'h0, 32'h5}));

    // Async reset while stalled clears outputs without a clock edge
    stall = 1'b1;
    #3 reset = 1'b1;
    #1;
    model_reset();
    compare_all("async_reset");
    check_eq("async_reset_wd", 128'(wb_wd), 128'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    stall = 1'b0;
    clear_inputs();

`ifdef WB_TRACE_EN
    for (int b = 0; b < 4; b++) begin
      set_lane(0, 1, 1, 0, 3'd0, 5'(2 * b + 1), $urandom, 32'h0);
      set_lane(1, 1, 1, 0, 3'd0, 5'(2 * b + 2), $urandom, 32'h0);
      step("trace_bundle");
    end
    check_eq("retire_cnt8", 128'(retire_cnt), 128'(32'd8));
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("retire_cnt_rst", 128'(retire_cnt), 128'(32'd0));
    @(posedge clk);
    #1 reset = 1'b0;
    clear_inputs();
`endif

    // Randomized traffic with small register range to hit WAW and r0
    for (int n = 0; n < 400; n++) begin
      in_valid    = LANES'($urandom);
      in_regwrite = LANES'($urandom);
      for (int i = 0; i < LANES; i++) begin
        in_kill[i] = ($urandom_range(0, 7) == 0);
        in_rdst[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 3));
        in_alu[i*DATA_W +: DATA_W]  = $urandom;
        in_mem[i*DATA_W +: DATA_W]  = $urandom;
        in_pc[i*DATA_W +: DATA_W]   = $urandom;
      end
      in_sel = (3*LANES)'($urandom);
      cp0_rd = $urandom; hi_rd = $urandom; lo_rd = $urandom;
      stall  = ($urandom_range(0, 5) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
